// File: rtl/model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_pkg.sv
// Shared constants and types for the multiplier-sharing scheduler:
// operand/product widths, multiplier latency, ID sizing and the shadow-stage record.
package model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_pkg;

  localparam int A_W       = 14;
  localparam int B_W       = 13;
  localparam int P_W       = 23;
  localparam int MUL_LAT   = 2;
  localparam int N_REQ_MAX = 8;
  localparam int STAT_W    = 16;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_MAX = id_width(N_REQ_MAX);

  // One entry per multiplier stage; id is sized for the largest legal N_REQ.
  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } shadow_t;

endpackage

// File: rtl/model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_if.sv
// Bundle of the requester, multiplier and response signals of the scheduler.
// slave = scheduler side, master = requesters / multiplier / downstream side.
interface model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_if #(
  parameter int N_REQ = 4
);
  import model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_pkg::*;

  localparam int ID_W = id_width(N_REQ);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // A producer holds valid and its payload unchanged until that edge; the
  // response channel therefore keeps rsp_* stable while rsp_valid && !rsp_ready.
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;

  logic                 mul_ce;
  logic [A_W-1:0]       mul_din0;
  logic [B_W-1:0]       mul_din1;
  logic [P_W-1:0]       mul_dout;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [P_W-1:0]       rsp_p;

  modport slave (
    input  req_valid, req_a, req_b, mul_dout, rsp_ready,
    output req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_p
  );

  modport master (
    output req_valid, req_a, req_b, mul_dout, rsp_ready,
    input  req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req_i searching
// upward from ptr_i and wrapping; returns one-hot grant, its index and any.
module model_nexys_pruned_5_hls4ml_prj_5_mul_share_rr_pick
  import model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  localparam int PW = ID_W + 1;

  logic [PW-1:0] pos;

  // pos carries one spare bit so ptr + k can be wrapped without overflow.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr_i} + PW'(k);
      if (pos >= PW'(N_REQ)) begin
        pos = pos - PW'(N_REQ);
      end
      if (!any_o && req_i[pos[ID_W-1:0]]) begin
        grant_o[pos[ID_W-1:0]] = 1'b1;
        idx_o                  = pos[ID_W-1:0];
        any_o                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb.sv
// Round-robin time-sharing of one pipelined multiplier among N_REQ requesters.
// Define MUL_SHARE_STATS_EN to add the stat_issue / stat_stall counter outputs.
module model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb
  import model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic clk,
  input  logic reset,
  model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_if.slave bus
`ifdef MUL_SHARE_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] stat_issue,
  output logic [STAT_W-1:0]       stat_stall
`endif
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  shadow_t          shadow_q [MUL_LAT];
  shadow_t          stage0_d;

  logic             mul_ce;
  logic             grant_en;
  logic             grant_vld;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [A_W-1:0]   din0;
  logic [B_W-1:0]   din1;
  logic             unused_shadow_id;

  // A held response freezes the multiplier, the shadow pipeline and arbitration.
  assign mul_ce    = !(shadow_q[MUL_LAT-1].valid && !bus.rsp_ready);
  assign grant_en  = mul_ce && reset;

  model_nexys_pruned_5_hls4ml_prj_5_mul_share_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign grant     = grant_en ? pick_grant : '0;
  assign grant_vld = grant_en && pick_any;

  always_comb begin
    din0 = '0;
    din1 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        din0 = bus.req_a[i*A_W +: A_W];
        din1 = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  always_comb begin
    stage0_d       = '0;
    stage0_d.valid = grant_vld;
    if (grant_vld) begin
      stage0_d.id = ID_W_MAX'(pick_idx);
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (mul_ce) begin
      rr_ptr_q    <= rr_ptr_d;
      shadow_q[0] <= stage0_d;
      for (int i = 1; i < MUL_LAT; i++) begin
        shadow_q[i] <= shadow_q[i-1];
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.mul_ce    = mul_ce;
  assign bus.mul_din0  = din0;
  assign bus.mul_din1  = din1;
  assign bus.rsp_valid = shadow_q[MUL_LAT-1].valid;
  assign bus.rsp_id    = shadow_q[MUL_LAT-1].id[ID_W-1:0];
  assign bus.rsp_p     = bus.mul_dout;

  // Upper id bits of the record are spare when N_REQ is below the maximum.
  assign unused_shadow_id = ^shadow_q[MUL_LAT-1].id;

`ifdef MUL_SHARE_STATS_EN
  logic [STAT_W-1:0] issue_cnt_q [N_REQ];
  logic [STAT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        issue_cnt_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && bus.req_valid[i] && (issue_cnt_q[i] != '1)) begin
          issue_cnt_q[i] <= issue_cnt_q[i] + STAT_W'(1);
        end
      end
      if (!mul_ce && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
    end
  end

  always_comb begin
    stat_issue = '0;
    for (int i = 0; i < N_REQ; i++) begin
      stat_issue[i*STAT_W +: STAT_W] = issue_cnt_q[i];
    end
  end

  assign stat_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb.sv
// Bench for the multiplier-sharing scheduler: behavioural 2-stage multiplier,
// per-scenario tasks and an expected-result queue fed on every accepted request.
`timescale 1ns/1ps
module tb_model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb;
  import model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_pkg::*;

  localparam int N_REQ = 4;
  localparam int ID_W  = id_width(N_REQ);
  localparam int EXP_W = ID_W + P_W;

  logic clk;
  logic reset;

  model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb_if #(.N_REQ(N_REQ)) bus();

`ifdef MUL_SHARE_STATS_EN
  logic [N_REQ*16-1:0] stat_issue;
  logic [15:0]         stat_stall;
`endif

  model_nexys_pruned_5_hls4ml_prj_5_mul_share_arb #(.N_REQ(N_REQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MUL_SHARE_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall)
`endif
  );

  int n_checks;
  int n_pass;
  logic [EXP_W-1:0] exp_q[$];
  logic             prev_hold;
  logic [EXP_W-1:0] prev_rsp;
  int               rr_exp;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, need completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference arithmetic / multiplier ----------------
  function automatic logic [P_W-1:0] model_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    logic [A_W+B_W:0] sa;
    logic [A_W+B_W:0] sb;
    logic [A_W+B_W:0] full;
    sa   = {{(B_W+1){a[A_W-1]}}, a};
    sb   = {{(A_W+1){1'b0}}, b};
    full = sa * sb;
    return full[P_W-1:0];
  endfunction

  logic [P_W-1:0] mq [MUL_LAT];
  always @(posedge clk) begin
    if (bus.mul_ce) begin
      mq[0] <= model_mul(bus.mul_din0, bus.mul_din1);
      for (int i = 1; i < MUL_LAT; i++) mq[i] <= mq[i-1];
    end
  end
  assign bus.mul_dout = mq[MUL_LAT-1];

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    bus.req_a[i*A_W +: A_W] = a;
    bus.req_b[i*B_W +: B_W] = b;
    bus.req_valid[i]        = 1'b1;
  endtask

  task automatic set_rand_op(input int i);
    set_op(i, A_W'($urandom_range(0, 16383)), B_W'($urandom_range(0, 8191)));
  endtask

  // Scoreboard sampling at the falling edge: pop on response transfer, push on accept.
  task automatic step_neg();
    logic [EXP_W-1:0] e;
    @(negedge clk);
    if (reset) begin
      n_checks++;
      if (!$onehot0(bus.req_ready)) $display("FAIL req_ready_onehot: got %b need one-hot or zero", bus.req_ready);
      else n_pass++;
      if (prev_hold) begin
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_p} !== {1'b1, prev_rsp})
          $display("FAIL rsp_hold: got v=%b id/p=%h need v=1 id/p=%h", bus.rsp_valid, {bus.rsp_id, bus.rsp_p}, prev_rsp);
        else n_pass++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rsp_unexpected: got id/p=%h need no response", {bus.rsp_id, bus.rsp_p});
        end else begin
          e = exp_q.pop_front();
          if ({bus.rsp_id, bus.rsp_p} !== e) $display("FAIL rsp_scoreboard: got id/p=%h need %h", {bus.rsp_id, bus.rsp_p}, e);
          else n_pass++;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          exp_q.push_back({ID_W'(i), model_mul(bus.req_a[i*A_W +: A_W], bus.req_b[i*B_W +: B_W])});
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_rsp  = {bus.rsp_id, bus.rsp_p};
    end else begin
      prev_hold = 1'b0;
    end
  endtask

  // Finish a cycle: accepted requesters either get fresh operands or drop valid.
  task automatic step_pos(input bit reload);
    logic [N_REQ-1:0] acc;
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i]) begin
        if (reload) set_rand_op(i);
        else bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.rsp_ready = 1'b1;
    while (exp_q.size() != 0 && k < 20) begin
      step_neg();
      step_pos(1'b0);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d outstanding need 0", exp_q.size());
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset         = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_rand_op(i);
    repeat (2) @(posedge clk);
    step_neg();
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b need 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.req_ready !== '0) $display("FAIL rst_req_ready: got %b need 0", bus.req_ready); else n_pass++;
    n_checks++; if (bus.mul_ce !== 1'b1) $display("FAIL rst_mul_ce: got %b need 1", bus.mul_ce); else n_pass++;
    n_checks++; if (bus.mul_din0 !== '0 || bus.mul_din1 !== '0)
      $display("FAIL rst_din: got %h/%h need 0/0", bus.mul_din0, bus.mul_din1); else n_pass++;
    n_checks++; if (bus.rsp_id !== '0) $display("FAIL rst_rsp_id: got %0d need 0", bus.rsp_id); else n_pass++;
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    reset         = 1'b1;
    step_neg();
    step_pos(1'b0);
    rr_exp = 0;
  endtask

  task automatic test_single(input int idx, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                             input logic [P_W-1:0] exp_p, input string name);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    set_op(idx, a, b);
    step_neg();
    n_checks++; if (bus.req_ready !== oh) $display("FAIL %s_grant: got %b need %b", name, bus.req_ready, oh); else n_pass++;
    n_checks++; if (bus.mul_din0 !== a || bus.mul_din1 !== b)
      $display("FAIL %s_din: got %h/%h need %h/%h", name, bus.mul_din0, bus.mul_din1, a, b); else n_pass++;
    step_pos(1'b0);
    step_neg();
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL %s_early: got rsp_valid=%b need 0", name, bus.rsp_valid); else n_pass++;
    step_pos(1'b0);
    step_neg();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(idx) || bus.rsp_p !== exp_p)
      $display("FAIL %s_rsp: got v=%b id=%0d p=%h need v=1 id=%0d p=%h", name, bus.rsp_valid, bus.rsp_id, bus.rsp_p, idx, exp_p);
    else n_pass++;
    step_pos(1'b0);
    rr_exp = (idx + 1) % N_REQ;
  endtask

  task automatic test_round_robin();
    logic [ID_W-1:0]  order [8];
    logic [N_REQ-1:0] oh;
    int               g;
    for (int i = 0; i < N_REQ; i++) set_rand_op(i);
    for (int c = 0; c < 10; c++) begin
      step_neg();
      if (c < 8) begin
        g        = (rr_exp + c) % N_REQ;
        order[c] = ID_W'(g);
        oh       = '0;
        oh[g]    = 1'b1;
        n_checks++; if (bus.req_ready !== oh) $display("FAIL rr_grant_c%0d: got %b need %b", c, bus.req_ready, oh); else n_pass++;
      end
      if (c >= 2) begin
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== order[c-2])
          $display("FAIL rr_rsp_c%0d: got v=%b id=%0d need v=1 id=%0d", c, bus.rsp_valid, bus.rsp_id, order[c-2]);
        else n_pass++;
      end
      step_pos(c < 7);
      if (c == 7) bus.req_valid = '0;
    end
    drain();
  endtask

  task automatic test_stall();
    logic [A_W-1:0] a0;
    logic [B_W-1:0] b0;
    logic [P_W-1:0] p0;
    a0 = A_W'($urandom_range(0, 16383));
    b0 = B_W'($urandom_range(1, 8191));
    p0 = model_mul(a0, b0);
    set_op(0, a0, b0);
    set_rand_op(1);
    set_rand_op(2);
    step_neg();
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL stall_g0: got %b need 0001", bus.req_ready); else n_pass++;
    step_pos(1'b0);
    step_neg();
    n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL stall_g1: got %b need 0010", bus.req_ready); else n_pass++;
    step_pos(1'b0);
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step_neg();
      n_checks++; if (bus.mul_ce !== 1'b0 || bus.req_ready !== '0)
        $display("FAIL stall_freeze_c%0d: got ce=%b ready=%b need ce=0 ready=0", c, bus.mul_ce, bus.req_ready); else n_pass++;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== '0 || bus.rsp_p !== p0)
        $display("FAIL stall_rsp_c%0d: got v=%b id=%0d p=%h need v=1 id=0 p=%h", c, bus.rsp_valid, bus.rsp_id, bus.rsp_p, p0);
      else n_pass++;
      step_pos(1'b0);
    end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step_neg();
      if (c == 0) begin
        n_checks++; if (bus.req_ready !== 4'b0100 || bus.mul_ce !== 1'b1)
          $display("FAIL stall_release_grant: got ready=%b ce=%b need 0100/1", bus.req_ready, bus.mul_ce); else n_pass++;
      end
      if (c < 3) begin
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(c))
          $display("FAIL stall_order_c%0d: got v=%b id=%0d need v=1 id=%0d", c, bus.rsp_valid, bus.rsp_id, c);
        else n_pass++;
      end else begin
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL stall_dup: got rsp_valid=%b need 0", bus.rsp_valid); else n_pass++;
      end
      step_pos(1'b0);
    end
    rr_exp = 3;
    drain();
  endtask

  task automatic test_reset_mid();
    set_rand_op(0);
    set_rand_op(2);
    step_neg();
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL rmid_g0: got %b need 0001", bus.req_ready); else n_pass++;
    step_pos(1'b0);
    step_neg();
    n_checks++; if (bus.req_ready !== 4'b0100) $display("FAIL rmid_g2: got %b need 0100", bus.req_ready); else n_pass++;
    step_pos(1'b0);
    reset = 1'b0;
    exp_q.delete();
    set_rand_op(1);
    set_rand_op(3);
    step_neg();
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0)
      $display("FAIL rmid_in_reset: got v=%b ready=%b need 0/0", bus.rsp_valid, bus.req_ready); else n_pass++;
    step_pos(1'b0);
    reset = 1'b1;
    step_neg();
    n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL rmid_first_grant: got %b need 0010", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmid_stale_r0: got rsp_valid=%b need 0", bus.rsp_valid); else n_pass++;
    step_pos(1'b0);
    step_neg();
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmid_stale_r1: got rsp_valid=%b need 0", bus.rsp_valid); else n_pass++;
    step_pos(1'b0);
    step_neg();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1)
      $display("FAIL rmid_new_rsp: got v=%b id=%0d need v=1 id=1", bus.rsp_valid, bus.rsp_id); else n_pass++;
    step_pos(1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int k;
    for (int c = 0; c < 200; c++) begin
      step_neg();
      step_pos(1'b0);
      for (int i = 0; i < N_REQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) set_rand_op(i);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.rsp_ready = 1'b1;
    k = 0;
    while (bus.req_valid != '0 && k < 20) begin
      step_neg();
      step_pos(1'b0);
      k++;
    end
    n_checks++; if (bus.req_valid !== '0) $display("FAIL b2b_starve: got pending %b need 0000", bus.req_valid); else n_pass++;
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks      = 0;
    n_pass        = 0;
    prev_hold     = 1'b0;
    prev_rsp      = '0;
    rr_exp        = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single(0, 14'd100, 13'd50, 23'd5000, "mul_basic");
    test_single(2, 14'h3FFD, 13'd5, 23'h7FFFF1, "mul_neg");
    test_single(3, 14'd1024, 13'd4096, 23'h400000, "mul_wrap");
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
